// File: rtl/branch_resolve_ctrl_pkg.sv
// Opcode/REGIMM constants, FSM encoding and branch decode helpers shared by the branch resolve sequencer.
package branch_resolve_ctrl_pkg;

  localparam logic [5:0] EXE_REGIMM_INST = 6'b000001;
  localparam logic [5:0] EXE_BEQ         = 6'b000100;
  localparam logic [5:0] EXE_BNE         = 6'b000101;
  localparam logic [5:0] EXE_BLEZ        = 6'b000110;
  localparam logic [5:0] EXE_BGTZ        = 6'b000111;

  localparam logic [4:0] EXE_BLTZ   = 5'b00000;
  localparam logic [4:0] EXE_BGEZ   = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL = 5'b10001;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_REDIRECT  = 2'd2
  } br_state_e;

  function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
    logic hit;
    hit = 1'b0;
    case (op)
      EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ: hit = 1'b1;
      EXE_REGIMM_INST: hit = (rt == EXE_BLTZ)   || (rt == EXE_BGEZ) ||
                             (rt == EXE_BLTZAL) || (rt == EXE_BGEZAL);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_two_operand(input logic [5:0] op);
    return (op == EXE_BEQ) || (op == EXE_BNE);
  endfunction

endpackage

// File: rtl/br_target_gen.sv
// Branch target = pc + 4 + (sign_ext(imm) << 2), modulo 2^32; purely combinational, no backpressure.
module br_target_gen (
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  output logic [31:0] target
);

  logic [31:0] offset;

  always_comb begin
    offset = {{14{imm[15]}}, imm, 2'b00};
    target = pc + 32'd4 + offset;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch sequencer: stalls ID on operand hazards, evaluates via the external comparator and
// issues a registered redirect one cycle after evaluation, held stable until fetch asserts redirect_ready.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter bit RESET_PC_HOLD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rt,
  input  logic [31:0]      id_pc,
  input  logic [15:0]      id_imm,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             rs_hazard,
  input  logic             rt_hazard,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  output logic [5:0]       cmp_op,
  output logic [4:0]       cmp_rt,
  input  logic             cmp_y,
  output logic             stall_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken,
  output logic [CNT_W-1:0] br_stall_cyc
);

  localparam logic [31:0]      PC_RST  = RESET_PC_HOLD ? RESET_PC : 32'h0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  br_state_e        state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] br_total_q, br_total_d;
  logic [CNT_W-1:0] br_taken_q, br_taken_d;
  logic [CNT_W-1:0] br_stall_q, br_stall_d;

  logic        id_branch;
  logic        need_hazard;
  logic        hazard_stall;
  logic        evaluate;
  logic [31:0] target;

  assign cmp_a  = rs_data;
  assign cmp_b  = rt_data;
  assign cmp_op = id_op;
  assign cmp_rt = id_rt;

  br_target_gen u_target (
    .pc     (id_pc),
    .imm    (id_imm),
    .target (target)
  );

  // Outside REDIRECT a branch either waits on operands or is evaluated in the same cycle.
  always_comb begin
    id_branch    = id_valid & is_branch(id_op, id_rt);
    need_hazard  = rs_hazard | (is_two_operand(id_op) & rt_hazard);
    hazard_stall = (state_q != ST_REDIRECT) & id_branch & need_hazard & ~flush;
    evaluate     = (state_q != ST_REDIRECT) & id_branch & ~need_hazard & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_OPND: begin
          if (hazard_stall)          state_d = ST_WAIT_OPND;
          else if (evaluate && cmp_y) state_d = ST_REDIRECT;
          else                        state_d = ST_IDLE;
        end
        ST_REDIRECT: begin
          if (redirect_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A branch sitting in the delay slot is held until the pending redirect is accepted.
  always_comb begin
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT_OPND: stall_id = hazard_stall;
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        stall_id       = id_branch & ~flush;
      end
      default: stall_id = 1'b0;
    endcase
    if (rst) stall_id = 1'b0;
  end

  always_comb begin
    redirect_pc_d = redirect_pc_q;
    br_total_d    = br_total_q;
    br_taken_d    = br_taken_q;
    br_stall_d    = br_stall_q;
    if (evaluate) begin
      br_total_d = br_total_q + CNT_ONE;
      if (cmp_y) begin
        br_taken_d    = br_taken_q + CNT_ONE;
        redirect_pc_d = target;
      end
    end
    if (hazard_stall) br_stall_d = br_stall_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_q <= PC_RST;
      br_total_q    <= '0;
      br_taken_q    <= '0;
      br_stall_q    <= '0;
    end else begin
      redirect_pc_q <= redirect_pc_d;
      br_total_q    <= br_total_d;
      br_taken_q    <= br_taken_d;
      br_stall_q    <= br_stall_d;
    end
  end

  assign redirect_pc  = redirect_pc_q;
  assign br_total     = br_total_q;
  assign br_taken     = br_taken_q;
  assign br_stall_cyc = br_stall_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed plan steps, then random traffic against a cycle-level reference model.
module tb_branch_resolve_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          id_valid;
  logic [5:0]    id_op;
  logic [4:0]    id_rt;
  logic [31:0]   id_pc;
  logic [15:0]   id_imm;
  logic [31:0]   rs_data;
  logic [31:0]   rt_data;
  logic          rs_hazard;
  logic          rt_hazard;
  logic [31:0]   cmp_a;
  logic [31:0]   cmp_b;
  logic [5:0]    cmp_op;
  logic [4:0]    cmp_rt;
  logic          cmp_y;
  logic          stall_id;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          redirect_ready;
  logic [CW-1:0] br_total;
  logic [CW-1:0] br_taken;
  logic [CW-1:0] br_stall_cyc;

  int n_cmp;
  int n_err;

  // Reference model: a pending redirect plus plain event counters.
  logic          m_pend;
  logic [31:0]   m_pc;
  logic [CW-1:0] m_total;
  logic [CW-1:0] m_taken;
  logic [CW-1:0] m_stall;

  branch_resolve_ctrl #(.CNT_W(CW), .RESET_PC_HOLD(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_op          (id_op),
    .id_rt          (id_rt),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .rs_hazard      (rs_hazard),
    .rt_hazard      (rt_hazard),
    .cmp_a          (cmp_a),
    .cmp_b          (cmp_b),
    .cmp_op         (cmp_op),
    .cmp_rt         (cmp_rt),
    .cmp_y          (cmp_y),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .br_total       (br_total),
    .br_taken       (br_taken),
    .br_stall_cyc   (br_stall_cyc)
  );

  always #5 clk = ~clk;

  function automatic logic ref_is_branch(input logic [5:0] op, input logic [4:0] rt);
    if (op >= 6'h04 && op <= 6'h07) return 1'b1;
    if (op == 6'h01) return rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11;
    return 1'b0;
  endfunction

  function automatic logic ref_taken(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'h04:   return a == b;
      6'h05:   return a != b;
      6'h06:   return $signed(a) <= 0;
      6'h07:   return $signed(a) > 0;
      6'h01:   return rt[0] ? ($signed(a) >= 0) : ($signed(a) < 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
    logic signed [15:0] s;
    int off;
    s   = imm;
    off = s;
    return pc + 32'd4 + 32'(off * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_op = 6'h00; id_rt = 5'h00;
    rs_hazard = 1'b0; rt_hazard = 1'b0; flush = 1'b0; redirect_ready = 1'b1;
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_pc = 32'hBFC0_0000; m_total = '0; m_taken = '0; m_stall = '0;
  endtask

  task automatic set_br(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] pc,
                        input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1; id_op = op; id_rt = rt; id_pc = pc; id_imm = imm; rs_data = a; rt_data = b;
  endtask

  // One clock: called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    logic br, need, stall_e;
    cmp_y = ref_taken(id_op, id_rt, rs_data, rt_data);
    #1;
    br      = id_valid && ref_is_branch(id_op, id_rt);
    need    = rs_hazard || ((id_op == 6'h04 || id_op == 6'h05) && rt_hazard);
    stall_e = !flush && br && (m_pend || need);
    chk("stall_id", 32'(stall_id), 32'(stall_e));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_pend));
    chk("redirect_pc", redirect_pc, m_pc);
    chk("br_total", 32'(br_total), 32'(m_total));
    chk("br_taken", 32'(br_taken), 32'(m_taken));
    chk("br_stall_cyc", 32'(br_stall_cyc), 32'(m_stall));
    chk("cmp_a", cmp_a, rs_data);
    chk("cmp_b", cmp_b, rt_data);
    chk("cmp_op_rt", {21'd0, cmp_op, cmp_rt}, {21'd0, id_op, id_rt});
    if (flush) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (redirect_ready) m_pend = 1'b0;
    end else if (br) begin
      if (need) begin
        m_stall = m_stall + 1'b1;
      end else begin
        m_total = m_total + 1'b1;
        if (cmp_y) begin
          m_taken = m_taken + 1'b1;
          m_pc    = ref_target(id_pc, id_imm);
          m_pend  = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'(int'($urandom_range(0, 3)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; idle();
    id_pc = '0; id_imm = '0; rs_data = '0; rt_data = '0; cmp_y = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 32'(redirect_valid), 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_pc", redirect_pc, 32'hBFC0_0000);
    chk("rst_cnt", {20'd0, br_total, br_taken, br_stall_cyc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Taken BEQ, accepted immediately; ADDIU in the delay slot proceeds.
    set_br(6'h04, 5'h00, 32'h0040_0000, 16'h0004, 32'd5, 32'd5);
    cycle();
    chk("beq_valid", 32'(redirect_valid), 32'd1);
    chk("beq_pc", redirect_pc, 32'h0040_0014);
    chk("beq_total", 32'(br_total), 32'd1);
    chk("beq_taken", 32'(br_taken), 32'd1);
    set_br(6'h09, 5'h00, 32'h0040_0004, 16'h0001, 32'd1, 32'd2);
    cycle();
    chk("beq_accepted", 32'(redirect_valid), 32'd0);

    // Not-taken BNE.
    set_br(6'h05, 5'h00, 32'h0040_0100, 16'h0010, 32'd7, 32'd7);
    cycle();
    chk("bne_valid", 32'(redirect_valid), 32'd0);
    chk("bne_total", 32'(br_total), 32'd2);
    chk("bne_taken", 32'(br_taken), 32'd1);

    // BGEZ waiting 3 cycles on rs; rt_hazard must not matter.
    set_br(6'h01, 5'h01, 32'h0040_0200, 16'h0008, 32'h8000_0000, 32'd0);
    rs_hazard = 1'b1; rt_hazard = 1'b1;
    repeat (3) cycle();
    chk("bgez_stall_cyc", 32'(br_stall_cyc), 32'd3);
    rs_hazard = 1'b0;
    cycle();
    chk("bgez_total", 32'(br_total), 32'd3);
    chk("bgez_valid", 32'(redirect_valid), 32'd0);

    // Backward BLTZ with fetch refusing the redirect for 4 cycles.
    idle();
    set_br(6'h01, 5'h00, 32'h0040_0010, 16'hFFFF, 32'hFFFF_FFFF, 32'd0);
    redirect_ready = 1'b0;
    cycle();
    idle();
    redirect_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bltz_hold_pc", redirect_pc, 32'h0040_0010);
      chk("bltz_hold_valid", 32'(redirect_valid), 32'd1);
      if (i == 4) redirect_ready = 1'b1;
      cycle();
    end
    chk("bltz_idle", 32'(redirect_valid), 32'd0);
    chk("bltz_taken", 32'(br_taken), 32'd2);

    // Flush during REDIRECT, then flush colliding with an evaluate.
    set_br(6'h04, 5'h00, 32'h0040_0300, 16'h0002, 32'd9, 32'd9);
    cycle();
    idle();
    flush = 1'b1;
    cycle();
    chk("flush_valid", 32'(redirect_valid), 32'd0);
    set_br(6'h04, 5'h00, 32'h0040_0400, 16'h0002, 32'd3, 32'd3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_eval_valid", 32'(redirect_valid), 32'd0);
    chk("flush_eval_total", 32'(br_total), 32'd5);

    // Branch in the delay slot: held until accept, then re-evaluated from IDLE.
    set_br(6'h04, 5'h00, 32'h0040_0500, 16'h0003, 32'd1, 32'd1);
    cycle();
    redirect_ready = 1'b0;
    cycle();
    redirect_ready = 1'b1;
    cycle();
    cycle();
    chk("slot_total", 32'(br_total), 32'd7);
    idle();
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: id_op = 6'h04;
        1: id_op = 6'h05;
        2: id_op = 6'h06;
        3: id_op = 6'h07;
        4, 5: id_op = 6'h01;
        6: id_op = 6'h09;
        7: id_op = 6'h23;
        8: id_op = 6'h00;
        default: id_op = 6'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: id_rt = 5'h00;
        1: id_rt = 5'h01;
        2: id_rt = 5'h10;
        3: id_rt = 5'h11;
        default: id_rt = 5'($urandom);
      endcase
      id_valid       = ($urandom_range(0, 9) < 8);
      id_pc          = $urandom & 32'hFFFF_FFFC;
      id_imm         = 16'($urandom);
      rs_data        = pick_val();
      rt_data        = ($urandom_range(0, 2) == 0) ? rs_data : pick_val();
      rs_hazard      = ($urandom_range(0, 9) < 3);
      rt_hazard      = ($urandom_range(0, 9) < 3);
      redirect_ready = ($urandom_range(0, 9) < 6);
      flush          = ($urandom_range(0, 19) == 0);
      cycle();
    end

    // Asynchronous reset while waiting on an operand.
    idle();
    cycle();
    cycle();
    set_br(6'h04, 5'h00, 32'h0040_0600, 16'h0001, 32'd2, 32'd2);
    rs_hazard = 1'b1;
    cycle();
    #1;
    chk("wait_stall", 32'(stall_id), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stall_id), 32'd0);
    chk("arst_valid", 32'(redirect_valid), 32'd0);
    chk("arst_pc", redirect_pc, 32'hBFC0_0000);
    chk("arst_cnt", {20'd0, br_total, br_taken, br_stall_cyc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
